// File: rtl/xcorr_window_pkg.sv
// Shared types, packing widths and helpers for the sliding-window cross-correlator.
package xcorr_window_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam int SAMPLE_W         = 32;              // {I[31:16],Q[15:0]}
    localparam int HALF_W           = 16;
    localparam int WIN_LEN          = 16;
    localparam int SLICE_LEN        = 4;
    localparam int LANES_W          = SLICE_LEN * SAMPLE_W;
    localparam int SUM_W            = 64;              // {I[63:32],Q[31:0]}
    localparam int ACC_W            = 34;
    localparam int MAG_W            = 35;
    localparam int MULT_LAT_DEFAULT = 5;

    // Default coefficient: (1,0) in {I,Q} packing.
    localparam logic [SAMPLE_W-1:0] COEFF_ONE = 32'h0001_0000;

    // Samples arrive as {I,Q}; stage_mult lanes want I in the low half (X2j) and Q above it (X2j+1).
    function automatic logic [SAMPLE_W-1:0] swap_iq(input logic [SAMPLE_W-1:0] s);
        return {s[HALF_W-1:0], s[SAMPLE_W-1:HALF_W]};
    endfunction

    // Magnitude of a two's-complement accumulator value; -2^33 maps to 2^33, which still fits.
    function automatic logic [ACC_W-1:0] abs_acc(input logic [ACC_W-1:0] v);
        return v[ACC_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/xcorr_window_coeff_rom.sv
// Coefficient ROM: one slice (four words, addresses 4k+0..4k+3) per read, registered output.
// Output lanes are already in stage_mult Y packing and read as zero when no read is requested.
module xcorr_coeff_rom
    import xcorr_window_pkg::*;
#(
    parameter logic [WIN_LEN*SAMPLE_W-1:0] COEFF_TABLE = {WIN_LEN{COEFF_ONE}}
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rd_en,
    input  logic [1:0]         slice,
    output logic [LANES_W-1:0] rd_data
);

    // Registered read of the addressed slice; zero between reads keeps mult_y quiet outside ISSUE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            for (int j = 0; j < SLICE_LEN; j++) begin
                rd_data[SAMPLE_W*j +: SAMPLE_W] <=
                    swap_iq(COEFF_TABLE[SAMPLE_W*(SLICE_LEN*int'(slice) + j) +: SAMPLE_W]);
            end
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/xcorr_window.sv
// Sliding-window complex cross-correlator: issues four 4-sample slices to stage_mult,
// accumulates the partial sums and reports correlation, |I|+|Q| and running-peak detection.
module xcorr_window
    import xcorr_window_pkg::*;
#(
    parameter int                          MULT_LAT    = MULT_LAT_DEFAULT,
    parameter logic [MAG_W-1:0]            THRESHOLD   = 35'd4096,
    parameter int                          TIMEOUT     = 16,
    parameter logic [WIN_LEN*SAMPLE_W-1:0] COEFF_TABLE = {WIN_LEN{COEFF_ONE}}
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_in_strobe,
    output logic                in_ready,
    output logic [LANES_W-1:0]  mult_x,
    output logic [LANES_W-1:0]  mult_y,
    output logic                mult_strobe,
    output logic                mult_enable,
    input  logic [SUM_W-1:0]    mult_sum,
    input  logic                mult_strobe_in,
    output logic [ACC_W-1:0]    corr_i,
    output logic [ACC_W-1:0]    corr_q,
    output logic [MAG_W-1:0]    corr_mag,
    output logic                corr_strobe,
    output logic                peak_valid,
    output logic [15:0]         peak_index,
    input  logic                peak_clear,
    output logic                overflow,
    output logic                error
);

    // Wait counter sized with room for the multiplier latency on top of the timeout.
    localparam int WAIT_CNT_W = $clog2(TIMEOUT + MULT_LAT + 1);

    state_t                state;
    logic [SAMPLE_W-1:0]   window [WIN_LEN];
    logic [15:0]           sample_count;
    logic [4:0]            fill_count;
    logic [1:0]            k;
    logic [1:0]            ret_cnt;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [ACC_W-1:0]      acc_i, acc_q;
    logic [MAG_W-1:0]      max_mag;

    logic                  rom_rd;
    logic [1:0]            rom_slice;
    logic [1:0]            k_next;
    logic [LANES_W-1:0]    first_x, next_x;
    logic [ACC_W-1:0]      next_i, next_q;
    logic [MAG_W-1:0]      next_mag, max_eff;
    logic                  window_full, new_peak;

    assign mult_enable = ~reset;
    assign k_next      = k + 2'd1;
    assign window_full = (fill_count == 5'(WIN_LEN));

    assign next_i   = acc_i + {{(ACC_W-32){mult_sum[63]}}, mult_sum[63:32]};
    assign next_q   = acc_q + {{(ACC_W-32){mult_sum[31]}}, mult_sum[31:0]};
    assign next_mag = {1'b0, abs_acc(next_i)} + {1'b0, abs_acc(next_q)};
    // A clear coinciding with a result takes effect before the compare.
    assign max_eff  = peak_clear ? '0 : max_mag;
    assign new_peak = (next_mag > max_eff) && (next_mag > THRESHOLD);

    // Slice operands: slice 0 comes from the window as it will look after the shift, later slices from the window.
    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
        first_x   = '0;
        next_x    = '0;
        rom_rd    = 1'b0;
        rom_slice = 2'd0;
        first_x[SAMPLE_W-1:0] = swap_iq(sample_in);
        for (int j = 1; j < SLICE_LEN; j++) begin
            first_x[SAMPLE_W*j +: SAMPLE_W] = swap_iq(window[j-1]);
        end
        for (int j = 0; j < SLICE_LEN; j++) begin
            next_x[SAMPLE_W*j +: SAMPLE_W] = swap_iq(window[{k_next, 2'(j)}]);
        end
        if (state == ST_IDLE && sample_in_strobe) begin
            rom_rd    = 1'b1;
            rom_slice = 2'd0;
        end else if (state == ST_ISSUE && k != 2'd3) begin
            rom_rd    = 1'b1;
            rom_slice = k_next;
        end
    end

    xcorr_coeff_rom #(
        .COEFF_TABLE(COEFF_TABLE)
    ) u_rom (
        .clock  (clock),
        .reset  (reset),
        .rd_en  (rom_rd),
        .slice  (rom_slice),
        .rd_data(mult_y)
    );

    // Control FSM with registered outputs: accept, issue four slices, collect four sums, report.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            // NOTE: the 16-entry window is a small register array, not a RAM, so clearing it on reset is cheap and required.
            for (int n = 0; n < WIN_LEN; n++) window[n] <= '0;
            sample_count <= '0;
            fill_count   <= '0;
            k            <= '0;
            ret_cnt      <= '0;
            wait_cnt     <= '0;
            acc_i        <= '0;
            acc_q        <= '0;
            max_mag      <= '0;
            in_ready     <= 1'b1;
            mult_x       <= '0;
            mult_strobe  <= 1'b0;
            corr_i       <= '0;
            corr_q       <= '0;
            corr_mag     <= '0;
            corr_strobe  <= 1'b0;
            peak_valid   <= 1'b0;
            peak_index   <= '0;
            overflow     <= 1'b0;
            error        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; the later peak update deliberately overrides the clear.
            corr_strobe <= 1'b0;
            peak_valid  <= 1'b0;
            if (peak_clear) max_mag <= '0;
            if (sample_in_strobe && !in_ready) overflow <= 1'b1;
            if (mult_strobe_in && (state == ST_IDLE || state == ST_ISSUE)) error <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (sample_in_strobe) begin
                        window[0] <= sample_in;
                        for (int n = 1; n < WIN_LEN; n++) window[n] <= window[n-1];
                        sample_count <= sample_count + 16'd1;
                        if (!window_full) fill_count <= fill_count + 5'd1;
                        k           <= 2'd0;
                        mult_x      <= first_x;
                        mult_strobe <= 1'b1;
                        in_ready    <= 1'b0;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (k == 2'd3) begin
                        mult_x      <= '0;
                        mult_strobe <= 1'b0;
                        ret_cnt     <= '0;
                        wait_cnt    <= '0;
                        state       <= ST_WAIT;
                    end else begin
                        k      <= k_next;
                        mult_x <= next_x;
                    end
                end
                ST_WAIT: begin
                    if (mult_strobe_in && ret_cnt == 2'd3) begin
                        corr_i      <= next_i;
                        corr_q      <= next_q;
                        corr_mag    <= next_mag;
                        corr_strobe <= window_full;
                        acc_i       <= '0;
                        acc_q       <= '0;
                        if (window_full && new_peak) begin
                            max_mag    <= next_mag;
                            peak_index <= sample_count;
                            peak_valid <= 1'b1;
                        end
                        state <= ST_DONE;
                    end else if (wait_cnt == WAIT_CNT_W'(TIMEOUT - 1)) begin
                        error    <= 1'b1;
                        acc_i    <= '0;
                        acc_q    <= '0;
                        in_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        if (mult_strobe_in) begin
                            acc_i   <= next_i;
                            acc_q   <= next_q;
                            ret_cnt <= ret_cnt + 2'd1;
                        end
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    in_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xcorr_window.sv
// Self-checking bench for xcorr_window with a behavioural stage_mult and a scoreboard of expected results.
module tb_xcorr_window;

    localparam int MULT_LAT = 5;

    logic         clock = 1'b0;
    logic         reset;
    logic [31:0]  sample_in;
    logic         sample_in_strobe;
    logic         in_ready;
    logic [127:0] mult_x, mult_y;
    logic         mult_strobe, mult_enable;
    logic [63:0]  mult_sum;
    logic         mult_strobe_in;
    logic [33:0]  corr_i, corr_q;
    logic [34:0]  corr_mag;
    logic         corr_strobe, peak_valid;
    logic [15:0]  peak_index;
    logic         peak_clear;
    logic         overflow, error;
    logic         suppress;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    xcorr_window dut (
        .clock           (clock),
        .reset           (reset),
        .sample_in       (sample_in),
        .sample_in_strobe(sample_in_strobe),
        .in_ready        (in_ready),
        .mult_x          (mult_x),
        .mult_y          (mult_y),
        .mult_strobe     (mult_strobe),
        .mult_enable     (mult_enable),
        .mult_sum        (mult_sum),
        .mult_strobe_in  (mult_strobe_in),
        .corr_i          (corr_i),
        .corr_q          (corr_q),
        .corr_mag        (corr_mag),
        .corr_strobe     (corr_strobe),
        .peak_valid      (peak_valid),
        .peak_index      (peak_index),
        .peak_clear      (peak_clear),
        .overflow        (overflow),
        .error           (error)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- behavioural stage_mult: sum of four complex products, MULT_LAT deep ----------------
    function automatic logic [63:0] cmac(input logic [127:0] x, input logic [127:0] y);
        longint si = 0, sq = 0, xi, xq, yi, yq;
        for (int j = 0; j < 4; j++) begin
            xi = $signed(x[32*j +: 16]);
            xq = $signed(x[32*j+16 +: 16]);
            yi = $signed(y[32*j +: 16]);
            yq = $signed(y[32*j+16 +: 16]);
            si += xi * yi - xq * yq;
            sq += xi * yq + xq * yi;
        end
        return {si[31:0], sq[31:0]};
    endfunction

    logic [MULT_LAT-1:0] pipe_v;
    logic [63:0]         pipe_sum [MULT_LAT];

    always @(posedge clock) begin
        if (!mult_enable) begin
            pipe_v <= '0;
        end else begin
            pipe_v      <= {pipe_v[MULT_LAT-2:0], mult_strobe};
            pipe_sum[0] <= cmac(mult_x, mult_y);
            for (int i = 1; i < MULT_LAT; i++) pipe_sum[i] <= pipe_sum[i-1];
        end
    end

    assign mult_strobe_in = pipe_v[MULT_LAT-1] & ~suppress;
    assign mult_sum       = pipe_sum[MULT_LAT-1];

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        longint ci;
        longint cq;
        longint mag;
        bit     pv;
        longint idx;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_win [16];
    logic [31:0] m_coef [16];
    int          m_count, m_fill;
    longint      m_max, m_idx;

    function automatic logic [31:0] mk(input int i, input int q);
        return {i[15:0], q[15:0]};
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 16; n++) begin
            m_win[n]  = '0;
            m_coef[n] = 32'h0001_0000;
        end
        m_count = 0;
        m_fill  = 0;
        m_max   = 0;
        m_idx   = 0;
        sb.delete();
    endtask

    task automatic model_accept(input logic [31:0] s, input bit produces);
        exp_t   e;
        longint si = 0, sq = 0, xi, xq, ci, cq;
        for (int n = 15; n > 0; n--) m_win[n] = m_win[n-1];
        m_win[0] = s;
        m_count  = (m_count + 1) & 16'hFFFF;
        if (m_fill < 16) m_fill++;
        if (m_fill == 16 && produces) begin
            for (int n = 0; n < 16; n++) begin
                xi = $signed(m_win[n][31:16]);
                xq = $signed(m_win[n][15:0]);
                ci = $signed(m_coef[n][31:16]);
                cq = $signed(m_coef[n][15:0]);
                si += xi * ci - xq * cq;
                sq += xi * cq + xq * ci;
            end
            e.ci  = si;
            e.cq  = sq;
            e.mag = (si < 0 ? -si : si) + (sq < 0 ? -sq : sq);
            e.pv  = (e.mag > m_max) && (e.mag > 4096);
            if (e.pv) begin
                m_max = e.mag;
                m_idx = m_count;
            end
            e.idx = m_idx;
            sb.push_back(e);
        end
    endtask

    // ---------------- output monitor ----------------
    int     n_corr = 0, n_peak = 0;
    longint last_i, last_q, last_mag, last_idx;

    always @(negedge clock) begin
        exp_t e;
        if (!reset && peak_valid && !corr_strobe) check("peak_without_corr", 1, 0);
        if (!reset && corr_strobe) begin
            n_corr++;
            last_i   = $signed(corr_i);
            last_q   = $signed(corr_q);
            last_mag = corr_mag;
            last_idx = peak_index;
            if (peak_valid) n_peak++;
            if (sb.size() == 0) begin
                check("unexpected_corr", 1, 0);
            end else begin
                e = sb.pop_front();
                check("corr_i", $signed(corr_i), e.ci);
                check("corr_q", $signed(corr_q), e.cq);
                check("corr_mag", corr_mag, e.mag);
                check("peak_valid", peak_valid, e.pv);
                check("peak_index", peak_index, e.idx);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [31:0] s);
        @(negedge clock);
        wait_ready();
        sample_in        = s;
        sample_in_strobe = 1'b1;
        model_accept(s, !suppress);
        @(negedge clock);
        sample_in_strobe = 1'b0;
    endtask

    task automatic settle();
        int n = 0;
        while ((!in_ready || sb.size() != 0) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("settle_sb_empty", sb.size(), 0);
        check("settle_in_ready", in_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_mult_enable"}, mult_enable, 0);
        check({tag, "_mult_x"}, mult_x != '0, 0);
        check({tag, "_mult_y"}, mult_y != '0, 0);
        check({tag, "_mult_strobe"}, mult_strobe, 0);
        check({tag, "_corr"}, (corr_i != '0) || (corr_q != '0) || (corr_mag != '0), 0);
        check({tag, "_strobes"}, {corr_strobe, peak_valid}, 0);
        check({tag, "_peak_index"}, peak_index, 0);
        check({tag, "_flags"}, {overflow, error}, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_reset_outputs("reset");
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    // ---------------- scenarios ----------------
    initial begin
        int cnt, base;
        reset            = 1'b1;
        sample_in        = '0;
        sample_in_strobe = 1'b0;
        peak_clear       = 1'b0;
        suppress         = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        check_reset_outputs("init");
        reset = 1'b0;
        @(negedge clock);
        check("enable_after_reset", mult_enable, 1);

        // 1: fill with (100,0); only the 16th sample yields a result, below threshold
        base = n_corr;
        repeat (16) send(mk(100, 0));
        settle();
        check("s1_corr_count", n_corr - base, 1);
        check("s1_corr_i", last_i, 1600);
        check("s1_corr_q", last_q, 0);
        check("s1_corr_mag", last_mag, 1600);
        check("s1_no_peak", n_peak, 0);

        // 2: fresh window of (300,-200): first result is a peak at sample 16
        do_reset();
        base = n_peak;
        repeat (16) send(mk(300, -200));
        settle();
        check("s2_corr_i", last_i, 4800);
        check("s2_corr_q", last_q, -3200);
        check("s2_corr_mag", last_mag, 8000);
        check("s2_peak_count", n_peak - base, 1);
        check("s2_peak_index", last_idx, 16);

        // 6: equal magnitude is no new peak; after peak_clear the same magnitude peaks again
        base = n_peak;
        send(mk(300, -200));
        settle();
        check("s6_equal_no_peak", n_peak - base, 0);
        @(negedge clock);
        peak_clear = 1'b1;
        m_max      = 0;
        @(negedge clock);
        peak_clear = 1'b0;
        base = n_peak;
        repeat (16) send(mk(300, -200));
        settle();
        check("s6_peak_after_clear", n_peak - base, 1);
        check("s6_peak_index", last_idx, 18);

        // 3: second strobe at cycle 5 is dropped; result at cycle 10, ready again at 11
        check("s3_overflow_pre", overflow, 0);
        base = n_corr;
        @(negedge clock);
        wait_ready();
        sample_in        = mk(-40, 70);
        sample_in_strobe = 1'b1;
        model_accept(mk(-40, 70), 1'b1);
        cnt = 0;
        do begin
            @(negedge clock);
            cnt++;
            if (cnt == 1) sample_in_strobe = 1'b0;
            if (cnt >= 1 && cnt <= 4) check("s3_mult_strobe_on", mult_strobe, 1);
            if (cnt == 5) begin
                check("s3_mult_strobe_off", mult_strobe, 0);
                check("s3_busy", in_ready, 0);
                sample_in        = mk(999, 999);
                sample_in_strobe = 1'b1;
            end
            if (cnt == 6) sample_in_strobe = 1'b0;
        end while (!corr_strobe && cnt < 40);
        check("s3_latency", cnt, 10);
        @(negedge clock);
        check("s3_ready_cycle11", in_ready, 1);
        check("s3_overflow", overflow, 1);
        settle();
        check("s3_corr_count", n_corr - base, 1);

        // 4: no returns from stage_mult -> timeout error at cycle 21, no result
        check("s4_error_pre", error, 0);
        base     = n_corr;
        suppress = 1'b1;
        @(negedge clock);
        wait_ready();
        sample_in        = mk(10, 10);
        sample_in_strobe = 1'b1;
        model_accept(mk(10, 10), 1'b0);
        cnt = 0;
        do begin
            @(negedge clock);
            cnt++;
            if (cnt == 1) sample_in_strobe = 1'b0;
        end while (!error && cnt < 60);
        check("s4_timeout_cycle", cnt, 21);
        check("s4_ready", in_ready, 1);
        repeat (5) @(negedge clock);
        suppress = 1'b0;
        check("s4_no_corr", n_corr - base, 0);

        // 5: reset in the middle of a computation, then a fresh window
        @(negedge clock);
        wait_ready();
        sample_in        = mk(5, 5);
        sample_in_strobe = 1'b1;
        cnt = 0;
        do begin
            @(negedge clock);
            cnt++;
            if (cnt == 1) sample_in_strobe = 1'b0;
        end while (cnt < 7);
        do_reset();
        base = n_corr;
        repeat (16) send(mk(-50, 25));
        settle();
        check("s5_corr_count", n_corr - base, 1);
        check("s5_corr_i", last_i, -800);
        check("s5_corr_q", last_q, 400);
        check("s5_corr_mag", last_mag, 1200);
        check("s5_flags_clean", {overflow, error}, 0);

        repeat (5) @(negedge clock);
        check("final_sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
